// File: rtl/move_scheduler.sv
// Gomoku turn sequencer: arbitrates the board write port between the human cursor
// and the AI move. The AI scans empty cells, requests one evaluation per cell and keeps the best.
// Define MOVE_SCHED_AI_FIRST_EN to let the AI open the game on the board centre.
module move_scheduler #(
   parameter int CELLS        = 121,
   parameter int ADDR_W       = 8,
   parameter int SCORE_W      = 16,
   parameter int EVAL_TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enter,
   input  logic [ADDR_W-1:0]  cursor_addr,
   output logic [ADDR_W-1:0]  occ_addr,
   input  logic               occ,
   input  logic               game_over,
   output logic               eval_req,
   output logic [ADDR_W-1:0]  eval_addr,
   input  logic               eval_ack,
   input  logic               eval_done,
   input  logic [SCORE_W-1:0] eval_score,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic               wr_player,
   output logic               player,
   output logic               busy,
   output logic [ADDR_W-1:0]  best_addr,
   output logic [SCORE_W-1:0] best_score,
   output logic               timeout_err
);

   localparam int TMR_W = $clog2(EVAL_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
   localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

   typedef enum logic [3:0] {
      H_TURN, H_WR, H_CHK, SCAN, REQ, WAIT, A_WR, A_CHK, DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [ADDR_W-1:0]          idx_q, idx_d;
   logic [ADDR_W-1:0]          eval_addr_q, eval_addr_d;
   logic [ADDR_W-1:0]          best_addr_q, best_addr_d;
   logic signed [SCORE_W-1:0]  best_score_q, best_score_d;
   logic                       found_q, found_d;
   logic                       player_q, player_d;
   logic [TMR_W-1:0]           tmr_q, tmr_d;
   logic                       tout_q, tout_d;
   logic                       timed_out;
   logic                       result_valid;
   logic signed [SCORE_W-1:0]  result_score;
`ifdef MOVE_SCHED_AI_FIRST_EN
   localparam logic [ADDR_W-1:0] CENTRE_CELL = ADDR_W'(60);
   logic                       ai_first_q, ai_first_d;
`endif

   // One budget covers both the ack wait and the result wait of a cell.
   assign timed_out    = (state_q == REQ || state_q == WAIT) &&
                         (tmr_q == TMR_W'(EVAL_TIMEOUT - 1));
   assign result_valid = timed_out || (state_q == WAIT && eval_done);
   assign result_score = (state_q == WAIT && eval_done) ? $signed(eval_score) : SCORE_MIN;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= H_TURN;
         idx_q        <= '0;
         eval_addr_q  <= '0;
         best_addr_q  <= '0;
         best_score_q <= SCORE_MIN;
         found_q      <= 1'b0;
         player_q     <= 1'b0;
         tmr_q        <= '0;
         tout_q       <= 1'b0;
`ifdef MOVE_SCHED_AI_FIRST_EN
         ai_first_q   <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         eval_addr_q  <= eval_addr_d;
         best_addr_q  <= best_addr_d;
         best_score_q <= best_score_d;
         found_q      <= found_d;
         player_q     <= player_d;
         tmr_q        <= tmr_d;
         tout_q       <= tout_d;
`ifdef MOVE_SCHED_AI_FIRST_EN
         ai_first_q   <= ai_first_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      eval_addr_d  = eval_addr_q;
      best_addr_d  = best_addr_q;
      best_score_d = best_score_q;
      found_d      = found_q;
      player_d     = player_q;
      tmr_d        = tmr_q;
      tout_d       = tout_q;
`ifdef MOVE_SCHED_AI_FIRST_EN
      ai_first_d   = ai_first_q;
`endif
      unique case (state_q)
         H_TURN: begin
`ifdef MOVE_SCHED_AI_FIRST_EN
            if (ai_first_q) begin
               ai_first_d  = 1'b0;
               best_addr_d = CENTRE_CELL;
               player_d    = 1'b1;
               state_d     = A_WR;
            end else if (enter && !occ && !game_over) begin
               state_d = H_WR;
            end
`else
            if (enter && !occ && !game_over) state_d = H_WR;
`endif
         end
         H_WR: state_d = H_CHK;
         H_CHK: begin
            if (game_over) begin
               state_d = DONE;
            end else begin
               player_d     = 1'b1;
               idx_d        = '0;
               best_score_d = SCORE_MIN;
               found_d      = 1'b0;
               state_d      = SCAN;
            end
         end
         SCAN: begin
            if (!occ) begin
               eval_addr_d = idx_q;
               tmr_d       = '0;
               state_d     = REQ;
            end else if (idx_q == LAST_CELL) begin
               state_d = found_q ? A_WR : DONE;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         REQ: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (eval_ack) state_d = WAIT;
         end
         WAIT: tmr_d = tmr_q + TMR_W'(1);
         A_WR: state_d = A_CHK;
         A_CHK: begin
            if (game_over) begin
               state_d = DONE;
            end else begin
               player_d = 1'b0;
               state_d  = H_TURN;
            end
         end
         DONE: state_d = DONE;
         default: state_d = H_TURN;
      endcase

      // A timed-out cell scores the minimum but can still be the first found cell.
      if (result_valid) begin
         if (timed_out) tout_d = 1'b1;
         if (!found_q || result_score > best_score_q) begin
            best_addr_d  = eval_addr_q;
            best_score_d = result_score;
            found_d      = 1'b1;
         end
         if (idx_q == LAST_CELL) begin
            state_d = A_WR;
         end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = SCAN;
         end
      end
   end

   always_comb begin
      occ_addr  = cursor_addr;
      eval_req  = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_player = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         H_TURN: busy = 1'b0;
         DONE:   busy = 1'b0;
         SCAN:   occ_addr = idx_q;
         REQ:    eval_req = 1'b1;
         H_WR: begin
            wr_en   = 1'b1;
            wr_addr = cursor_addr;
         end
         A_WR: begin
            wr_en     = 1'b1;
            wr_addr   = best_addr_q;
            wr_player = 1'b1;
         end
         default: ;
      endcase
   end

   assign eval_addr   = eval_addr_q;
   assign player      = player_q;
   assign best_addr   = best_addr_q;
   assign best_score  = best_score_q;
   assign timeout_err = tout_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: board and evaluator models, hand-computed expectations.
module tb_move_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        enter;
   logic [7:0]  cursor_addr;
   logic [7:0]  occ_addr;
   logic        occ;
   logic        game_over;
   logic        eval_req;
   logic [7:0]  eval_addr;
   logic        eval_ack;
   logic        eval_done;
   logic [15:0] eval_score;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic        wr_player;
   logic        player;
   logic        busy;
   logic [7:0]  best_addr;
   logic [15:0] best_score;
   logic        timeout_err;

   move_scheduler dut (
      .clk(clk), .rst(rst), .enter(enter), .cursor_addr(cursor_addr),
      .occ_addr(occ_addr), .occ(occ), .game_over(game_over),
      .eval_req(eval_req), .eval_addr(eval_addr), .eval_ack(eval_ack),
      .eval_done(eval_done), .eval_score(eval_score),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_player(wr_player),
      .player(player), .busy(busy), .best_addr(best_addr),
      .best_score(best_score), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic       board [256];
   assign occ = board[occ_addr];

   int   score_mode  = 0;
   int   no_ack_cell = 255;
   int   evals       = 0;
   int   first_eval  = -1;
   int   last_eval   = -1;
   logic pend        = 1'b0;
   int   pend_cnt    = 0;
   logic [7:0] pend_addr = '0;

   int   wr_cnt = 0;
   int   last_wr_addr = -1;
   int   last_wr_pl = -1;
   int   req_cell1 = 0;
   int   req_any = 0;
   logic go_on_write = 1'b0;

   // Evaluator: ack on the first request cycle, result two cycles later.
   always @(negedge clk) begin
      eval_ack  = 1'b0;
      eval_done = 1'b0;
      if (pend) begin
         if (pend_cnt == 0) begin
            eval_done = 1'b1;
            case (score_mode)
               0: eval_score = 16'(int'(pend_addr));
               1: eval_score = 16'd5;
               default: eval_score = 16'(int'(pend_addr) - 60);
            endcase
            pend = 1'b0;
            $display("eval addr=%0d score=%0d", pend_addr, $signed(eval_score));
         end else begin
            pend_cnt--;
         end
      end else if (eval_req && (int'(eval_addr) != no_ack_cell)) begin
         eval_ack  = 1'b1;
         pend      = 1'b1;
         pend_cnt  = 1;
         pend_addr = eval_addr;
         if (first_eval < 0) first_eval = int'(eval_addr);
         last_eval = int'(eval_addr);
         evals++;
      end
   end

   // Board model and write/request monitor.
   always @(negedge clk) begin
      if (eval_req) req_any++;
      if (eval_req && eval_addr == 8'd1) req_cell1++;
      if (wr_en) begin
         board[wr_addr] = 1'b1;
         wr_cnt++;
         last_wr_addr = int'(wr_addr);
         last_wr_pl   = int'(wr_player);
         $display("write addr=%0d player=%0d", wr_addr, wr_player);
         if (go_on_write && !wr_player) game_over = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clear_logs();
      for (int i = 0; i < 256; i++) board[i] = 1'b0;
      evals = 0; first_eval = -1; last_eval = -1;
      wr_cnt = 0; req_cell1 = 0; req_any = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      clear_logs();
      rst = 1'b1;
   endtask

   task automatic pulse_enter();
      @(negedge clk);
      enter = 1'b1;
      @(negedge clk);
      enter = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int cyc);
      cyc = 1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
         cyc++;
      end
      check("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   int cyc;
   int base_wr;
   int base_ev;

   initial begin
      rst = 1'b0; enter = 1'b0; cursor_addr = 8'd37; game_over = 1'b0;
      for (int i = 0; i < 256; i++) board[i] = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_occ_addr", {24'd0, occ_addr}, 32'd37);
      check("rst_best_score", {16'd0, best_score}, 32'h8000);
      rst = 1'b1;
      @(negedge clk);
      check("rst_player", {31'd0, player}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_eval_req", {31'd0, eval_req}, 32'd0);
      check("rst_best_addr", {24'd0, best_addr}, 32'd0);
      check("rst_tout", {31'd0, timeout_err}, 32'd0);

      // Empty board, score = address: AI must take cell 120.
      cursor_addr = 8'd0; score_mode = 0;
      pulse_enter();
      wait_idle(2000, cyc);
      check("t1_cycles", cyc, 32'd485);
      check("t1_writes", wr_cnt, 32'd2);
      check("t1_evals", evals, 32'd120);
      check("t1_first_eval", first_eval, 32'd1);
      check("t1_last_eval", last_eval, 32'd120);
      check("t1_ai_addr", last_wr_addr, 32'd120);
      check("t1_ai_player", last_wr_pl, 32'd1);
      check("t1_best_score", {16'd0, best_score}, 32'd120);
      check("t1_player", {31'd0, player}, 32'd0);

      // Commit on an occupied cell is dropped.
      base_wr = wr_cnt;
      cursor_addr = 8'd0;
      pulse_enter();
      repeat (3) @(negedge clk);
      check("t2_no_write", wr_cnt, base_wr);
      check("t2_busy", {31'd0, busy}, 32'd0);
      check("t2_player", {31'd0, player}, 32'd0);

      // Equal scores: lowest empty cell wins.
      base_ev = evals;
      cursor_addr = 8'd1; score_mode = 1;
      pulse_enter();
      wait_idle(2000, cyc);
      check("t3_evals", evals - base_ev, 32'd118);
      check("t3_best_addr", {24'd0, best_addr}, 32'd2);
      check("t3_ai_addr", last_wr_addr, 32'd2);
      check("t3_best_score", {16'd0, best_score}, 32'd5);

      // Signed scores addr-60: maximum at the highest empty cell.
      base_ev = evals;
      cursor_addr = 8'd3; score_mode = 2;
      pulse_enter();
      wait_idle(2000, cyc);
      check("t4_evals", evals - base_ev, 32'd116);
      check("t4_ai_addr", last_wr_addr, 32'd119);
      check("t4_best_score", {16'd0, best_score}, 32'd59);

      // Evaluator never answers cell 1.
      do_reset();
      cursor_addr = 8'd0; score_mode = 1; no_ack_cell = 1;
      pulse_enter();
      wait_idle(10000, cyc);
      check("t5_tout", {31'd0, timeout_err}, 32'd1);
      check("t5_req_cycles", req_cell1, 32'd4096);
      check("t5_evals", evals, 32'd119);
      check("t5_ai_addr", last_wr_addr, 32'd2);
      check("t5_ai_player", last_wr_pl, 32'd1);
      no_ack_cell = 255;

      // Human wins: terminal state, no evaluation, later commits ignored.
      do_reset();
      check("t6_tout_cleared", {31'd0, timeout_err}, 32'd0);
      cursor_addr = 8'd5; go_on_write = 1'b1;
      pulse_enter();
      wait_idle(100, cyc);
      check("t6_writes", wr_cnt, 32'd1);
      check("t6_no_req", req_any, 32'd0);
      check("t6_player", {31'd0, player}, 32'd0);
      go_on_write = 1'b0; game_over = 1'b0; cursor_addr = 8'd6;
      pulse_enter();
      repeat (3) @(negedge clk);
      check("t6_done_ignores", wr_cnt, 32'd1);
      check("t6_busy", {31'd0, busy}, 32'd0);

      // Reset while waiting on the third evaluation.
      do_reset();
      cursor_addr = 8'd0; score_mode = 0;
      pulse_enter();
      for (int i = 0; i < 200 && evals < 3; i++) @(negedge clk);
      @(negedge clk);
      check("t7_pre_best", {16'd0, best_score}, 32'd2);
      check("t7_pre_player", {31'd0, player}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t7_req_async", {31'd0, eval_req}, 32'd0);
      check("t7_busy_async", {31'd0, busy}, 32'd0);
      check("t7_player_async", {31'd0, player}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("t7_player", {31'd0, player}, 32'd0);
      check("t7_busy", {31'd0, busy}, 32'd0);
      check("t7_best_score", {16'd0, best_score}, 32'h8000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Turn sequencer for the 11x11 Gomoku board. It arbitrates the single board write port between the human cursor commit and the AI move. On the AI turn it scans every empty cell, requests one NNUE evaluation per empty cell, and keeps the best-scoring cell. It sits between the debounced input and cursor logic, the board state block (occupancy, win detection) and the NNUE evaluator.

Parameters:
CELLS, 121, number of board cells; cell addresses run 0..CELLS-1
ADDR_W, 8, cell address width
SCORE_W, 16, signed evaluation score width
EVAL_TIMEOUT, 4096, maximum cycles spent on one evaluation, counted from eval_req assertion

Ports:
clk  in  1  system clock (25 MHz domain)
rst  in  1  reset, asynchronous, active-low
enter  in  1  one-cycle human commit pulse
cursor_addr  in  ADDR_W  human cursor cell
occ_addr  out  ADDR_W  occupancy query address
occ  in  1  occupancy of occ_addr, combinational, same cycle
game_over  in  1  win/draw flag from board state, valid 1 cycle after a write
eval_req  out  1  evaluation request
eval_addr  out  ADDR_W  candidate cell, stable while eval_req is high
eval_ack  in  1  evaluator accepted the request
eval_done  in  1  one-cycle result strobe
eval_score  in  SCORE_W  signed score, valid with eval_done
wr_en  out  1  board write strobe, 1 cycle
wr_addr  out  ADDR_W  board write cell
wr_player  out  1  owner of the written stone: 0 = human, 1 = AI
player  out  1  side to move
busy  out  1  high in every state except H_TURN and DONE
best_addr  out  ADDR_W  best cell of the current or last scan
best_score  out  SCORE_W  best score of the current or last scan
timeout_err  out  1  sticky evaluation-timeout flag

Behaviour:
- Reset values: all outputs 0, except best_score = most-negative value and occ_addr = cursor_addr. State after reset is H_TURN.
- Reset asserted mid-operation returns the block to H_TURN immediately. eval_req drops asynchronously. A pending eval_done arriving after reset is ignored.
- States: H_TURN, H_WR, H_CHK, SCAN, REQ, WAIT, A_WR, A_CHK, DONE.
- H_TURN:
  - player=0; occ_addr=cursor_addr.
  - Go to H_WR when enter & !occ & !game_over.
  - enter on an occupied cell is dropped.
  - enter in any other state is ignored; it is not queued.
- H_WR: wr_en=1, wr_addr=cursor_addr, wr_player=0, then H_CHK.
- H_CHK (1 cycle):
  - If game_over, go to DONE.
  - Otherwise: player=1, idx=0, best_score=min, found=0, then SCAN.
- SCAN:
  - occ_addr=idx.
  - Occupied cell: idx++ in the same cycle.
  - Empty cell: latch eval_addr=idx, go to REQ.
  - Leaving at idx=CELLS-1: go to A_WR if found, else DONE (draw).
- REQ: eval_req held high until the cycle eval_ack=1, then drop it and go to WAIT. The ack cycle counts as accepted.
- WAIT:
  - On eval_done, compare signed eval_score > best_score.
  - If greater: update best_addr/best_score and set found=1.
  - Ties keep the lower address. The first empty cell always sets found=1.
  - Then idx++ and return to SCAN, or apply the end rule if idx was CELLS-1.
- Timeout:
  - One counter runs over REQ+WAIT and resets on entry to REQ.
  - On reaching EVAL_TIMEOUT: drop eval_req, set timeout_err=1, and treat the cell as score=min. It is still eligible as the first found cell.
  - Proceed as for eval_done.
- A_WR: wr_en=1, wr_addr=best_addr, wr_player=1, then A_CHK.
- A_CHK: game_over leads to DONE; otherwise player=0 and H_TURN.
- DONE: terminal, no writes, left only by reset.
- Per-scan latency: 1 cycle per occupied cell; 1 + ack wait + done wait per empty cell.
- wr_en is never asserted during a scan. At most one eval is outstanding.

Optional Feature:
MOVE_SCHED_AI_FIRST_EN:
- Defined: after reset the AI moves first. The state goes H_TURN -> A_WR with best_addr=60 (board centre), no scan, player=1. The rest of the flow is unchanged.
- Undefined: the human moves first, as above.

Test Plan:
- Empty board, enter with cursor=0, evaluator returns score=idx for every cell -> wr_en with addr 0 player 0; 120 evals at addrs 1..120; A_WR addr 120 player 1; player returns to 0.
- Cursor on an occupied cell, enter -> no wr_en, state stays H_TURN, busy=0.
- All evals return 5 -> best_addr = lowest empty cell (tie rule).
- Evaluator never acks at cell 1 -> after 4096 cycles timeout_err=1; the scan continues at cell 2; the final move is a valid empty cell.
- game_over=1 after the human write -> DONE, no eval_req; further enter is ignored.
- Reset low during WAIT -> eval_req=0 the same cycle; after release player=0, busy=0, best_score=min.
